// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Frame controller around a bit-serial Mealy pattern detector with
//            a programmable pattern and saturating match counter.
//            Define SEQ_CTRL_OVERLAP_EN for overlapping detection.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int             PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1001,
    parameter int             FRAME_LEN = 16,
    parameter int             CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    localparam int c_FILL_W = $clog2(PAT_W + 1);
    localparam int c_BIT_W  = $clog2(FRAME_LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
    localparam logic [c_FILL_W-1:0] c_FILL_ARM = c_FILL_W'(PAT_W - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(FRAME_LEN - 1);

`ifdef SEQ_CTRL_OVERLAP_EN
    localparam logic [c_FILL_W-1:0] c_FILL_AFTER_MATCH = c_FILL_MAX;
`else
    localparam logic [c_FILL_W-1:0] c_FILL_AFTER_MATCH = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [PAT_W-1:0]    r_pattern;
    logic [PAT_W-2:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]    r_match_cnt;
    logic                r_busy;
    logic                r_bit_ready;
    logic                r_done;

    logic                w_accept;
    logic [PAT_W-1:0]    w_window;
    logic                w_match;

    // abort wins over a bit offered in the same cycle
    assign w_accept = r_bit_ready & bit_valid & ~abort;
    assign w_window = {r_hist, bit_in};
    assign w_match  = w_accept && (r_fill >= c_FILL_ARM) && (w_window == r_pattern);

    assign bit_ready = r_bit_ready;
    assign match     = w_match;
    assign match_cnt = r_match_cnt;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pattern   <= PAT_INIT;
            r_hist      <= '0;
            r_fill      <= '0;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_busy      <= 1'b0;
            r_bit_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (cfg_we) begin
                        r_pattern <= cfg_pattern;
                    end
                    if (start) begin
                        r_state     <= S_RUN;
                        r_hist      <= '0;
                        r_fill      <= '0;
                        r_bit_cnt   <= '0;
                        r_match_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_bit_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_bit_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_hist    <= w_window[PAT_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_match) begin
                            r_fill <= c_FILL_AFTER_MATCH;
                            if (r_match_cnt != {CNT_W{1'b1}}) begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else if (r_fill != c_FILL_MAX) begin
                            r_fill <= r_fill + 1'b1;
                        end
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_bit_ready <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_bit_ready <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
